// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: owns the PC, fetches over req/rdy, holds instr for decode until acked
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [15:0]      imem_addr,
    input  logic             imem_rdy,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      instr,
    output logic [15:0]      pc,
    output logic             instr_valid,
    input  logic             instr_ack,
    input  logic [15:0]      alt_pc,
    input  logic             alt_pc_ctrl,
    input  logic             hlt,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      pc_q, pc_nxt;
    logic [15:0]      instr_q, instr_nxt;
    logic [CNT_W-1:0] ret_q, ret_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            ret_q   <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            ret_q   <= ret_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        ret_nxt   = ret_q;
        case (state)
            FETCH: begin
                if (imem_rdy) begin
                    instr_nxt = imem_rdata;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (instr_ack) begin
                    ret_nxt = ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (hlt) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_nxt    = alt_pc_ctrl ? alt_pc : pc_q + 16'd1;
                        state_nxt = FETCH;
                    end
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = FETCH;
        endcase
    end

    // Gating with rst_n drops an outstanding request the moment reset asserts.
    assign imem_req    = (state == FETCH) && rst_n;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state == VALID);
    assign halted      = (state == HALTED);
    assign retired     = ret_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_rdata;
    logic [15:0] rdata_drv;
    logic        auto_mem;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        instr_valid;
    logic        instr_ack;
    logic [15:0] alt_pc;
    logic        alt_pc_ctrl;
    logic        hlt;
    logic        halted;
    logic [15:0] retired;

    int n_cmp = 0;
    int n_bad = 0;

    logic track6 = 1'b1;
    logic saw6   = 1'b0;

    always #5 clk = ~clk;

    assign imem_rdata = auto_mem ? imem_addr : rdata_drv;

    always @(posedge clk) begin
        if (track6 && rst_n && imem_req && imem_addr == 16'h0006) saw6 = 1'b1;
    end

    instr_fetch #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .alt_pc(alt_pc), .alt_pc_ctrl(alt_pc_ctrl), .hlt(hlt),
        .halted(halted), .retired(retired)
    );

    function automatic logic [66:0] ov(input logic rq, input logic [15:0] ad, input logic vl,
                                       input logic [15:0] ins, input logic [15:0] p,
                                       input logic hl, input logic [15:0] rt);
        return {rq, ad, vl, ins, p, hl, rt};
    endfunction

    function automatic logic [66:0] outs();
        return {imem_req, imem_addr, instr_valid, instr, pc, halted, retired};
    endfunction

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_rdy = 1'b0; rdata_drv = 16'h0000; instr_ack = 1'b0;
        alt_pc = 16'h0000; alt_pc_ctrl = 1'b0; hlt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("in_reset", outs(), ov(0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("req_after_reset", {66'd0, imem_req}, 67'd1);
    endtask

    typedef struct {
        logic        rdy;
        logic [15:0] rdata;
        logic        ack;
        logic        actl;
        logic [15:0] apc;
        logic        h;
        logic [66:0] exp;
    } vec_t;

    vec_t tbl[10];

    // Behavioural reference: "holding an instruction" and "stopped" as plain flags.
    logic [15:0] m_pc, m_instr, m_ret;
    logic        m_have, m_stop;

    initial begin
        logic [15:0] r0;
        int          reqs;

        auto_mem = 1'b0;
        rst_n    = 1'b0;
        idle_inputs();

        tbl[0] = '{1, 16'h1234, 0, 0, 16'h0000, 0, ov(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0)};
        tbl[1] = '{0, 16'h0000, 1, 0, 16'h0000, 0, ov(0, 16'h0000, 1, 16'h1234, 16'h0000, 0, 16'd0)};
        tbl[2] = '{0, 16'h0000, 0, 0, 16'h0000, 0, ov(1, 16'h0001, 0, 16'h1234, 16'h0001, 0, 16'd1)};
        tbl[3] = '{1, 16'h5555, 0, 0, 16'h0000, 0, ov(1, 16'h0001, 0, 16'h1234, 16'h0001, 0, 16'd1)};
        tbl[4] = '{1, 16'h0000, 0, 1, 16'h0040, 1, ov(0, 16'h0001, 1, 16'h5555, 16'h0001, 0, 16'd1)};
        tbl[5] = '{0, 16'h0000, 1, 1, 16'h0040, 0, ov(0, 16'h0001, 1, 16'h5555, 16'h0001, 0, 16'd1)};
        tbl[6] = '{1, 16'hBEEF, 1, 0, 16'h0000, 1, ov(1, 16'h0040, 0, 16'h5555, 16'h0040, 0, 16'd2)};
        tbl[7] = '{0, 16'h0000, 1, 1, 16'h0099, 1, ov(0, 16'h0040, 1, 16'hBEEF, 16'h0040, 0, 16'd2)};
        tbl[8] = '{1, 16'hAAAA, 1, 1, 16'h0011, 0, ov(0, 16'h0040, 0, 16'hBEEF, 16'h0040, 1, 16'd3)};
        tbl[9] = '{0, 16'h0000, 0, 0, 16'h0000, 0, ov(0, 16'h0040, 0, 16'hBEEF, 16'h0040, 1, 16'd3)};

        // Table vectors: outputs checked first, then the row's inputs are applied for the next edge.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
            imem_rdy = tbl[i].rdy; rdata_drv = tbl[i].rdata; instr_ack = tbl[i].ack;
            alt_pc_ctrl = tbl[i].actl; alt_pc = tbl[i].apc; hlt = tbl[i].h;
            tick();
        end

        // Zero-wait sequential fetch, mem[a] = a, ack tied high.
        do_reset();
        saw6 = 1'b0;
        auto_mem = 1'b1; imem_rdy = 1'b1; instr_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                chk($sformatf("seq_fetch%0d", i), {outs()[66:50], outs()[32]},
                    {1'b1, 16'(i / 2), 1'b0});
            else
                chk($sformatf("seq_valid%0d", i), {outs()[66], outs()[49:17]},
                    {1'b0, 1'b1, 16'(i / 2), 16'(i / 2)});
            tick();
        end
        chk("seq_retired", {51'd0, retired}, 67'd4);
        tick(); tick(); tick();
        chk("at_pc5", {65'd0, instr_valid, pc == 16'h0005}, 67'd3);

        // Redirect from pc 5 to 0x40.
        alt_pc_ctrl = 1'b1; alt_pc = 16'h0040;
        tick();
        alt_pc_ctrl = 1'b0;
        chk("redirect", {50'd0, imem_req, imem_addr}, {50'd0, 1'b1, 16'h0040});

        // Stall five cycles in VALID.
        tick();
        instr_ack = 1'b0;
        r0 = retired;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d", i), outs(), ov(0, 16'h0040, 1, 16'h0040, 16'h0040, 0, r0));
            tick();
        end
        instr_ack = 1'b1;
        imem_rdy = 1'b0;
        tick();
        chk("stall_release", {51'd0, retired}, {51'd0, r0 + 16'd1});

        // Three wait states then rdy: request and address stable for four cycles.
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wait%0d", k), {outs()[66:50], outs()[32]}, {1'b1, 16'h0041, 1'b0});
            if (k == 3) imem_rdy = 1'b1;
            tick();
        end
        chk("wait_valid", {outs()[66], outs()[49:17], outs()[15:0]},
            {1'b0, 1'b1, 16'h0041, 16'h0041, r0 + 16'd1});

        // Halt at pc 0x10 with alt_pc_ctrl also set: halt wins.
        alt_pc_ctrl = 1'b1; alt_pc = 16'h0010;
        tick();
        alt_pc_ctrl = 1'b0;
        tick();
        r0 = retired;
        hlt = 1'b1; alt_pc_ctrl = 1'b1; alt_pc = 16'h0077;
        tick();
        hlt = 1'b0; alt_pc_ctrl = 1'b0;
        chk("halt", outs(), ov(0, 16'h0010, 0, 16'h0010, 16'h0010, 1, r0 + 16'd1));
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) reqs++;
            tick();
        end
        chk("halt_no_req", {35'd0, reqs}, 67'd0);
        chk("halt_frozen", {50'd0, halted, retired}, {50'd0, 1'b1, r0 + 16'd1});
        chk("never_req6", {66'd0, saw6}, 67'd0);
        track6 = 1'b0;

        // Asynchronous reset while halted, checked between clock edges.
        #2 rst_n = 1'b0;
        #1 chk("async_rst_halted", outs(), ov(0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Wrap: redirect to 0xFFFF, sequential accept -> 0x0000, then on to 1.
        imem_rdy = 1'b1; instr_ack = 1'b1; alt_pc_ctrl = 1'b1; alt_pc = 16'hFFFF;
        tick();
        tick();
        alt_pc_ctrl = 1'b0;
        chk("at_ffff", {50'd0, imem_req, imem_addr}, {50'd0, 1'b1, 16'hFFFF});
        tick();
        tick();
        chk("wrap", {50'd0, imem_req, imem_addr}, {50'd0, 1'b1, 16'h0000});
        tick();
        imem_rdy = 1'b0;
        tick();
        tick();
        chk("pending_fetch", {50'd0, imem_req, imem_addr}, {50'd0, 1'b1, 16'h0001});

        // Asynchronous reset with a request outstanding.
        #2 rst_n = 1'b0;
        #1 chk("async_rst_fetch", outs(), ov(0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized stimulus against the reference model, several reset episodes.
        auto_mem = 1'b0;
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            m_pc = 16'h0000; m_instr = 16'h0000; m_ret = 16'h0000; m_have = 1'b0; m_stop = 1'b0;
            for (int c = 0; c < 400; c++) begin
                chk("rand", outs(), ov(!m_have && !m_stop, m_pc, m_have, m_instr, m_pc, m_stop, m_ret));
                imem_rdy    = ($urandom_range(0, 3) != 0);
                rdata_drv   = 16'($urandom);
                instr_ack   = ($urandom_range(0, 2) != 0);
                alt_pc_ctrl = ($urandom_range(0, 3) == 0);
                alt_pc      = 16'($urandom);
                hlt         = ($urandom_range(0, 40) == 0);
                if (!m_stop) begin
                    if (m_have) begin
                        if (instr_ack) begin
                            m_ret  = m_ret + 16'd1;
                            m_have = 1'b0;
                            if (hlt) m_stop = 1'b1;
                            else     m_pc = alt_pc_ctrl ? alt_pc : m_pc + 16'd1;
                        end
                    end else if (imem_rdy) begin
                        m_instr = rdata_drv;
                        m_have  = 1'b1;
                    end
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
